conv_window_gen: RTL and testbench

Streaming 3x3 window generator that feeds the convolver MAC. Accepts a raster-order pixel stream with a valid/ready handshake and buffers two image rows internally. For every valid (unpadded, stride-1) output position, it presents the nine window taps on registered outputs, which connect directly to the MAC's nine line inputs and its enable. Frame geometry is programmed per frame; a start/done pair brackets each frame.

---
 rtl/conv_pkg.sv | 19 +
 rtl/conv_window_gen_line_buffer.sv | 26 ++
 rtl/conv_window_gen.sv | 156 +++++++++++++++
 tb/tb_conv_window_gen.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types for the streaming 3x3 window generator (conv_window_gen).
// Pixel width comes from the WID_LINE macro; it defaults to 16 bits when not set.
`ifndef WID_LINE
`define WID_LINE 16
`endif

package conv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } wingen_state_t;

  localparam int WIN_TAPS = 9;

  typedef logic signed [`WID_LINE-1:0] pix_t;

endpackage

// File: rtl/conv_window_gen_line_buffer.sv
// One image row of storage: combinational read and clocked write at the same
// address, so a read in the cycle of a write returns the old contents.
module line_buffer
  import conv_pkg::*;
#(
  parameter int MAX_W = 256,
  parameter int AW    = $clog2(MAX_W)
) (
  input  logic                        clk,
  input  logic                        we,
  input  logic [AW-1:0]               addr,
  input  logic signed [`WID_LINE-1:0] wdata,
  output logic signed [`WID_LINE-1:0] rdata
);

  pix_t mem [MAX_W];

  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/conv_window_gen.sv
// Streaming 3x3 window generator: raster pixels in, nine registered taps out.
// Optional feature: WINGEN_PERF_CNT_EN adds the win_count consumed-window counter.
module conv_window_gen
  import conv_pkg::*;
#(
  parameter int MAX_W = 256,
  parameter int CW    = $clog2(MAX_W)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [CW:0]                 img_width,
  input  logic [CW:0]                 img_height,
  input  logic signed [`WID_LINE-1:0] in_pixel,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic signed [`WID_LINE-1:0] win_1,
  output logic signed [`WID_LINE-1:0] win_2,
  output logic signed [`WID_LINE-1:0] win_3,
  output logic signed [`WID_LINE-1:0] win_4,
  output logic signed [`WID_LINE-1:0] win_5,
  output logic signed [`WID_LINE-1:0] win_6,
  output logic signed [`WID_LINE-1:0] win_7,
  output logic signed [`WID_LINE-1:0] win_8,
  output logic signed [`WID_LINE-1:0] win_9,
  output logic                        win_valid,
  input  logic                        win_ready,
  output logic                        busy,
  output logic                        done,
  output logic                        cfg_err,
`ifdef WINGEN_PERF_CNT_EN
  output logic [31:0]                 win_count,
`endif
  output wingen_state_t               state
);

  localparam logic [CW:0] MIN_DIM = (CW+1)'(3);
  localparam logic [CW:0] MAX_DIM = (CW+1)'(MAX_W);
  localparam logic [CW:0] ONE     = (CW+1)'(1);

  wingen_state_t state_q, state_d;
  logic [CW:0]   width_q, height_q, row_q;
  logic [CW-1:0] col_q;
  pix_t          tap [WIN_TAPS];
  pix_t          lb0_rd, lb1_rd;
  logic          legal, start_ok, accept, last_col, last_row, emit;

  // Handshakes: a beat transfers on a rising edge where valid && ready; the
  // sender holds data stable while valid && !ready; ready never waits on valid.
  assign legal    = (img_width >= MIN_DIM) && (img_width <= MAX_DIM) && (img_height >= MIN_DIM);
  assign start_ok = (state_q == IDLE) && start && legal;
  assign in_ready = (state_q == RUN) && (!win_valid || win_ready);
  assign accept   = in_valid && in_ready;
  assign last_col = ({1'b0, col_q} == (width_q - ONE));
  assign last_row = (row_q == (height_q - ONE));
  assign emit     = (row_q >= (CW+1)'(2)) && (col_q >= CW'(2));
  assign busy     = (state_q != IDLE);
  assign state    = state_q;

  line_buffer #(.MAX_W(MAX_W), .AW(CW)) lb0 (
    .clk(clk), .we(accept), .addr(col_q), .wdata(in_pixel), .rdata(lb0_rd)
  );

  line_buffer #(.MAX_W(MAX_W), .AW(CW)) lb1 (
    .clk(clk), .we(accept), .addr(col_q), .wdata(lb0_rd), .rdata(lb1_rd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    case (state_q)
      IDLE:    if (start_ok) state_d = RUN;
      RUN:     if (accept && last_col && last_row) state_d = DRAIN;
      DRAIN: begin
        if (!win_valid || win_ready) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      width_q   <= '0;
      height_q  <= '0;
      row_q     <= '0;
      col_q     <= '0;
      win_valid <= 1'b0;
      cfg_err   <= 1'b0;
      for (int i = 0; i < WIN_TAPS; i++) tap[i] <= '0;
    end else begin
      cfg_err <= (state_q == IDLE) && start && !legal;
      if (start_ok) begin
        width_q  <= img_width;
        height_q <= img_height;
        row_q    <= '0;
        col_q    <= '0;
      end
      if (accept) begin
        if (last_col) begin
          col_q <= '0;
          row_q <= row_q + ONE;
        end else begin
          col_q <= col_q + CW'(1);
        end
        // Columns from the previous row stay in the window at row start; emit masks them.
        for (int k = 0; k < 3; k++) begin
          tap[3*k]   <= tap[3*k+1];
          tap[3*k+1] <= tap[3*k+2];
        end
        tap[2]    <= lb1_rd;
        tap[5]    <= lb0_rd;
        tap[8]    <= in_pixel;
        win_valid <= emit;
      end else if (win_ready) begin
        win_valid <= 1'b0;
      end
    end
  end

  assign win_1 = tap[0];
  assign win_2 = tap[1];
  assign win_3 = tap[2];
  assign win_4 = tap[3];
  assign win_5 = tap[4];
  assign win_6 = tap[5];
  assign win_7 = tap[6];
  assign win_8 = tap[7];
  assign win_9 = tap[8];

`ifdef WINGEN_PERF_CNT_EN
  logic consume;
  assign consume = win_valid && win_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_count <= '0;
    end else if (start_ok) begin
      win_count <= '0;
    end else if (consume && (win_count != '1)) begin
      win_count <= win_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_conv_window_gen.sv
// Self-checking bench for conv_window_gen: directed frames plus random data,
// compared against windows computed directly from each stored frame.
`ifndef WID_LINE
`define WID_LINE 16
`endif

module tb_conv_window_gen;
  import conv_pkg::*;

  localparam int MAX_W = 256;
  localparam int CW    = $clog2(MAX_W);
  localparam int WL    = `WID_LINE;

  typedef logic [9*WL-1:0] win_t;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 start = 1'b0;
  logic [CW:0]          img_width = '0;
  logic [CW:0]          img_height = '0;
  logic signed [WL-1:0] in_pixel = '0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic signed [WL-1:0] win_1, win_2, win_3, win_4, win_5, win_6, win_7, win_8, win_9;
  logic                 win_valid;
  logic                 win_ready = 1'b0;
  logic                 busy, done, cfg_err;
`ifdef WINGEN_PERF_CNT_EN
  logic [31:0]          win_count;
`endif
  wingen_state_t        state;

  int errors = 0;
  int checks = 0;

  logic [WL-1:0] frame_px[$];
  logic [9*WL-1:0] exp_q[$];
  int  fw = 0, fh = 0, n_acc = 0, consumed = 0;
  bit  running = 0, drain_m = 0, exp_wv = 0;

  conv_window_gen #(.MAX_W(MAX_W), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .img_width(img_width), .img_height(img_height),
    .in_pixel(in_pixel), .in_valid(in_valid), .in_ready(in_ready),
    .win_1(win_1), .win_2(win_2), .win_3(win_3),
    .win_4(win_4), .win_5(win_5), .win_6(win_6),
    .win_7(win_7), .win_8(win_8), .win_9(win_9),
    .win_valid(win_valid), .win_ready(win_ready),
    .busy(busy), .done(done), .cfg_err(cfg_err),
`ifdef WINGEN_PERF_CNT_EN
    .win_count(win_count),
`endif
    .state(state)
  );

  always #5 clk = ~clk;

  function automatic win_t obs_win();
    return {win_1, win_2, win_3, win_4, win_5, win_6, win_7, win_8, win_9};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_win(input string tag, input win_t obs, input win_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: every window is cut straight out of the stored frame.
  task automatic load_frame(input int w, input int h, input bit ramp);
    fw = w;
    fh = h;
    frame_px.delete();
    exp_q.delete();
    for (int i = 0; i < w*h; i++) frame_px.push_back(ramp ? WL'(i) : WL'($urandom));
    for (int r = 2; r < h; r++) begin
      for (int c = 2; c < w; c++) begin
        win_t wv = '0;
        for (int dr = 0; dr < 3; dr++)
          for (int dc = 0; dc < 3; dc++)
            wv = {wv[8*WL-1:0], frame_px[(r-2+dr)*w + (c-2+dc)]};
        exp_q.push_back(wv);
      end
    end
  endtask

  task automatic do_start(input int w, input int h);
    bit legal = (w >= 3) && (w <= MAX_W) && (h >= 3);
    @(negedge clk);
    start      = 1'b1;
    img_width  = (CW+1)'(w);
    img_height = (CW+1)'(h);
    @(posedge clk);
    if (legal) begin
      running  = 1;
      drain_m  = 0;
      n_acc    = 0;
      consumed = 0;
      exp_wv   = 0;
    end
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("cfg_err_after_start", cfg_err, !legal);
    chk("busy_after_start", busy, legal);
    chk("in_ready_after_start", in_ready, legal);
`ifdef WINGEN_PERF_CNT_EN
    chk("win_count_after_start", win_count, consumed);
`endif
    if (!legal) begin
      @(negedge clk);
      #1;
      chk("cfg_err_pulse_end", cfg_err, 0);
      chk("busy_illegal", busy, 0);
      chk("in_ready_illegal", in_ready, 0);
    end
  endtask

  // mode 0: always ready; mode 1: 3-cycle stall on the second window; mode 2: random gaps.
  task automatic run_frame(input int mode, input int max_acc);
    int budget = 4*fw*fh + 200;
    int cyc = 0;
    int stall_left = 3;
    bit finished = 0;
    while (!finished && cyc < budget && !(max_acc > 0 && n_acc >= max_acc)) begin
      bit exp_rdy, acc, cons, exp_done;
      wingen_state_t exp_state;
      @(negedge clk);
      in_valid = (n_acc < fw*fh) && (mode != 2 || $urandom_range(0, 3) != 0);
      if (n_acc < fw*fh) in_pixel = frame_px[n_acc];
      if (mode == 1 && consumed == 1 && exp_wv && stall_left > 0) begin
        win_ready = 1'b0;
        stall_left--;
      end else if (mode == 2) begin
        win_ready = ($urandom_range(0, 2) != 0);
      end else begin
        win_ready = 1'b1;
      end
      #1;
      exp_rdy   = running && (!exp_wv || win_ready);
      acc       = in_valid && exp_rdy;
      cons      = exp_wv && win_ready;
      exp_done  = drain_m && (!exp_wv || win_ready);
      exp_state = running ? RUN : (drain_m ? DRAIN : IDLE);
      chk("in_ready", in_ready, exp_rdy);
      chk("win_valid", win_valid, exp_wv);
      chk("done", done, exp_done);
      chk("busy", busy, running || drain_m);
      chk("state", state, exp_state);
      if (exp_wv) begin
        checks++;
        assert (exp_q.size() > 0) else begin
          errors++;
          $error("FAIL extra_window observed=%0h expected=none", obs_win());
        end
        if (exp_q.size() > 0) chk_win("window", obs_win(), exp_q[0]);
      end
`ifdef WINGEN_PERF_CNT_EN
      chk("win_count", win_count, consumed);
`endif
      cyc++;
      @(posedge clk);
      if (cons && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        consumed++;
      end
      if (exp_done) begin
        drain_m  = 0;
        finished = 1;
      end
      if (acc) begin
        int r = n_acc / fw;
        int c = n_acc % fw;
        exp_wv = (r >= 2) && (c >= 2);
        n_acc++;
        if (n_acc == fw*fh) begin
          running = 0;
          drain_m = 1;
        end
      end else if (win_ready) begin
        exp_wv = 0;
      end
    end
    if (max_acc == 0) begin
      checks++;
      assert (finished) else begin
        errors++;
        $error("FAIL frame_timeout observed=no_done expected=done within %0d cycles", budget);
      end
      chk("windows_left", exp_q.size(), 0);
      @(negedge clk);
      in_valid  = 1'b0;
      win_ready = 1'b1;
      #1;
      chk("done_after_frame", done, 0);
      chk("busy_after_frame", busy, 0);
      chk("win_valid_after_frame", win_valid, 0);
      chk("state_after_frame", state, IDLE);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_win_valid", win_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_state", state, IDLE);
    chk_win("rst_taps", obs_win(), '0);
`ifdef WINGEN_PERF_CNT_EN
    chk("rst_win_count", win_count, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    load_frame(4, 4, 1);
    do_start(4, 4);
    run_frame(0, 0);

    load_frame(4, 4, 1);
    do_start(4, 4);
    run_frame(1, 0);

    do_start(2, 4);
    do_start(MAX_W + 1, 4);
    do_start(4, 2);

    load_frame(MAX_W, 3, 1);
    do_start(MAX_W, 3);
    run_frame(0, 0);

    repeat (4) begin
      int w = $urandom_range(3, 12);
      int h = $urandom_range(3, 7);
      load_frame(w, h, 0);
      do_start(w, h);
      run_frame(2, 0);
    end

    load_frame(5, 5, 0);
    do_start(5, 5);
    run_frame(0, 6);
    #2;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    running  = 0;
    drain_m  = 0;
    exp_wv   = 0;
    consumed = 0;
    #1;
    chk("midrst_win_valid", win_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_state", state, IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    load_frame(5, 5, 0);
    do_start(5, 5);
    run_frame(0, 0);

    load_frame(5, 4, 1);
    do_start(5, 4);
    run_frame(2, 0);
`ifdef WINGEN_PERF_CNT_EN
    chk("win_count_frame_5x4", win_count, 6);
`endif
    load_frame(5, 4, 0);
    do_start(5, 4);
    run_frame(0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
